mem_bus_arbiter: RTL

- Shares the single RAM port between the instruction cache (read-only requester) and the data cache controller (read/write requester).
- Registered-grant arbiter with burst locking: one cache can move a whole block (BURST_LEN words) without interleaving.
- Sits between the caches' memory-side signals and the RAM/memory controller.
- Fixed priority (dcache first) by default. Round-robin is an optional build.

---
 rtl/mem_bus_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester RAM port arbiter (icache read-only, dcache read/write) with burst locking.
// Fixed dcache priority from IDLE; define ARB_RR_EN for round-robin tie-breaking from IDLE.
module mem_bus_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic [1:0]        grant,
    output logic              bus_err
);
    localparam int BW = ($clog2(BURST_LEN) < 2) ? 2 : $clog2(BURST_LEN);
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE = 2'd0, IGNT = 2'd1, DGNT = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          d_req, i_req, done, last_beat, pick_d;

    assign d_req     = dREN | dWEN;
    assign i_req     = iREN;
    assign done      = (ramstate == RS_ACCESS) | (ramstate == RS_ERROR);
    assign last_beat = (beat_q == BW'(BURST_LEN - 1));

`ifdef ARB_RR_EN
    // last_q: 1 = dcache was the most recent owner
    logic last_q;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                 last_q <= 1'b0;
        else if (state_d == DGNT)  last_q <= 1'b1;
        else if (state_d == IGNT)  last_q <= 1'b0;
    end
    assign pick_d = (d_req & i_req) ? ~last_q : d_req;
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Owner dropping its request releases immediately; a full burst only yields if the other side waits.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                beat_d = '0;
                if (pick_d)     state_d = DGNT;
                else if (i_req) state_d = IGNT;
            end
            IGNT: begin
                if (!i_req) begin
                    beat_d  = '0;
                    state_d = d_req ? DGNT : IDLE;
                end else if (done) begin
                    if (last_beat) begin
                        beat_d = '0;
                        if (d_req) state_d = DGNT;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            DGNT: begin
                if (!d_req) begin
                    beat_d  = '0;
                    state_d = i_req ? IGNT : IDLE;
                end else if (done) begin
                    if (last_beat) begin
                        beat_d = '0;
                        if (i_req) state_d = IGNT;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        grant    = {state_q == DGNT, state_q == IGNT};
        bus_err  = (state_q != IDLE) & (ramstate == RS_ERROR);
        case (state_q)
            IGNT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                iload   = ramload;
                iwait   = ~done;
            end
            DGNT: begin
                ramaddr  = daddr;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramstore = dstore;
                dload    = ramload;
                dwait    = ~done;
            end
            default: ;
        endcase
    end
endmodule
